// File: rtl/register_file_if.sv
// Register file access bus: decode-stage read ports and write-back write port.
interface register_file_if #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned AW   = 5
);
   logic [AW-1:0]   read_reg1;
   logic [AW-1:0]   read_reg2;
   logic [AW-1:0]   write_reg;
   logic [XLEN-1:0] write_data;
   logic            reg_write;
   logic [XLEN-1:0] read_data1;
   logic [XLEN-1:0] read_data2;

   // Pipeline side: issues indices and write-back data, consumes read data.
   modport master (
      output read_reg1, read_reg2, write_reg, write_data, reg_write,
      input  read_data1, read_data2
   );

   // Register file side.
   modport slave (
      input  read_reg1, read_reg2, write_reg, write_data, reg_write,
      output read_data1, read_data2
   );
endinterface

// File: rtl/register_file.sv
// Integer register file: NREGS x XLEN flops, two combinational read ports,
// one synchronous write port, x0 hardwired to zero, optional write-to-read bypass.
module register_file #(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned NREGS  = 32,
   parameter int unsigned AW     = 5,
   parameter bit          BYPASS = 1'b1
) (
   input logic            clk,
   input logic            rst,
   register_file_if.slave bus
);

   logic [XLEN-1:0] regs_q [NREGS];
   logic [XLEN-1:0] rdata1;
   logic [XLEN-1:0] rdata2;
   logic            wr_en;

   // x0 is never written, so its flop stays at the reset value.
   assign wr_en = bus.reg_write && (bus.write_reg != '0);

   // Register array: synchronous clear has priority over the write port.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= '0;
         end
      end else if (wr_en) begin
         regs_q[bus.write_reg] <= bus.write_data;
      end
   end

   // Read port 1: reset and x0 force zero; bypass only when the write is enabled.
   always_comb begin
      rdata1 = '0;
      if (!rst && (bus.read_reg1 != '0)) begin
         if (BYPASS && bus.reg_write && (bus.write_reg == bus.read_reg1)) begin
            rdata1 = bus.write_data;
         end else begin
            rdata1 = regs_q[bus.read_reg1];
         end
      end
   end

   // Read port 2: same selection rules as port 1.
   always_comb begin
      rdata2 = '0;
      if (!rst && (bus.read_reg2 != '0)) begin
         if (BYPASS && bus.reg_write && (bus.write_reg == bus.read_reg2)) begin
            rdata2 = bus.write_data;
         end else begin
            rdata2 = regs_q[bus.read_reg2];
         end
      end
   end

   assign bus.read_data1 = rdata1;
   assign bus.read_data2 = rdata2;

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench: a bypassing and a non-bypassing register file driven with
// identical stimulus and compared against an array-based reference model.
module tb_register_file;
   localparam int unsigned XLEN  = 32;
   localparam int unsigned NREGS = 32;
   localparam int unsigned AW    = 5;

   logic            clk = 1'b0;
   logic            rst;
   logic [AW-1:0]   read_reg1;
   logic [AW-1:0]   read_reg2;
   logic [AW-1:0]   write_reg;
   logic [XLEN-1:0] write_data;
   logic            reg_write;

   int errors = 0;
   int checks = 0;

   // Reference model: architectural register contents.
   logic [XLEN-1:0] model [NREGS];

   register_file_if #(.XLEN(XLEN), .AW(AW)) bus_b ();
   register_file_if #(.XLEN(XLEN), .AW(AW)) bus_n ();

   assign bus_b.read_reg1  = read_reg1;
   assign bus_b.read_reg2  = read_reg2;
   assign bus_b.write_reg  = write_reg;
   assign bus_b.write_data = write_data;
   assign bus_b.reg_write  = reg_write;
   assign bus_n.read_reg1  = read_reg1;
   assign bus_n.read_reg2  = read_reg2;
   assign bus_n.write_reg  = write_reg;
   assign bus_n.write_data = write_data;
   assign bus_n.reg_write  = reg_write;

   register_file #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW), .BYPASS(1'b1)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (bus_b)
   );

   register_file #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW), .BYPASS(1'b0)) dut_n (
      .clk (clk),
      .rst (rst),
      .bus (bus_n)
   );

   always #5 clk = ~clk;

   // Architectural read rule applied to the current inputs and model contents.
   function automatic logic [XLEN-1:0] expect_rd(input logic [AW-1:0] idx, input bit bypass);
      if (rst) return '0;
      if (idx == '0) return '0;
      if (bypass && reg_write && write_reg == idx) return write_data;
      return model[idx];
   endfunction

   // [0]=bypass port1, [1]=bypass port2, [2]=plain port1, [3]=plain port2
   function automatic logic [3:0][XLEN-1:0] observed();
      return {bus_n.read_data2, bus_n.read_data1, bus_b.read_data2, bus_b.read_data1};
   endfunction

   function automatic logic [3:0][XLEN-1:0] expected();
      return {expect_rd(read_reg2, 1'b0), expect_rd(read_reg1, 1'b0),
              expect_rd(read_reg2, 1'b1), expect_rd(read_reg1, 1'b1)};
   endfunction

   // One rising edge; model commits with the same inputs the DUTs sample.
   task automatic tick();
      @(posedge clk);
      if (rst) begin
         for (int i = 0; i < NREGS; i++) model[i] = '0;
      end else if (reg_write && write_reg != '0) begin
         model[write_reg] = write_data;
      end
      #1;
   endtask

   task automatic test_reset();
      logic [3:0][XLEN-1:0] obs;
      rst = 1'b1; reg_write = 1'b1; write_reg = 5'd4; write_data = $urandom;
      read_reg1 = 5'd4; read_reg2 = 5'd9;
      #1;
      tick();
      obs = observed();
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (obs[k] !== '0) begin
            errors++;
            $display("FAIL reset_held port%0d: got %h want 0", k, obs[k]);
         end
      end
      rst = 1'b0; reg_write = 1'b0;
      for (int i = 1; i < NREGS; i++) begin
         read_reg1 = AW'(i); read_reg2 = AW'(NREGS - i);
         #1;
         obs = observed();
         for (int k = 0; k < 4; k++) begin
            checks++;
            if (obs[k] !== '0) begin
               errors++;
               $display("FAIL reset_clear i=%0d port%0d: got %h want 0", i, k, obs[k]);
            end
         end
      end
   endtask

   task automatic test_basic_write();
      reg_write = 1'b1; write_reg = 5'd5; write_data = 32'd123;
      tick();
      write_reg = 5'd10; write_data = 32'd999;
      tick();
      reg_write = 1'b0; write_data = $urandom;
      read_reg1 = 5'd5; read_reg2 = 5'd10;
      for (int rep = 0; rep < 2; rep++) begin
         #1;
         checks++;
         if (bus_b.read_data1 !== 32'd123 || bus_n.read_data1 !== 32'd123) begin
            errors++;
            $display("FAIL basic_x5 rep%0d: got %0d/%0d want 123", rep,
                     bus_b.read_data1, bus_n.read_data1);
         end
         checks++;
         if (bus_b.read_data2 !== 32'd999 || bus_n.read_data2 !== 32'd999) begin
            errors++;
            $display("FAIL basic_x10 rep%0d: got %0d/%0d want 999", rep,
                     bus_b.read_data2, bus_n.read_data2);
         end
         repeat (3) tick();
      end
   endtask

   task automatic test_x0();
      logic [3:0][XLEN-1:0] obs;
      reg_write = 1'b1; write_reg = '0; write_data = 32'hDEADBEEF;
      read_reg1 = '0; read_reg2 = '0;
      for (int phase = 0; phase < 2; phase++) begin
         #1;
         obs = observed();
         for (int k = 0; k < 4; k++) begin
            checks++;
            if (obs[k] !== '0) begin
               errors++;
               $display("FAIL x0_zero phase%0d port%0d: got %h want 0", phase, k, obs[k]);
            end
         end
         tick();
         reg_write = 1'b0;
      end
   endtask

   task automatic test_bypass();
      reg_write = 1'b1; write_reg = 5'd7; write_data = 32'd11;
      tick();
      // Enable low: old value on both variants.
      reg_write = 1'b0; write_data = 32'd55; read_reg1 = 5'd7; read_reg2 = 5'd7;
      #1;
      checks++;
      if (bus_b.read_data1 !== 32'd11 || bus_n.read_data1 !== 32'd11) begin
         errors++;
         $display("FAIL bypass_disabled_we: got %0d/%0d want 11",
                  bus_b.read_data1, bus_n.read_data1);
      end
      reg_write = 1'b1;
      #1;
      checks++;
      if (bus_b.read_data1 !== 32'd55 || bus_b.read_data2 !== 32'd55) begin
         errors++;
         $display("FAIL bypass_fwd: got %0d/%0d want 55", bus_b.read_data1, bus_b.read_data2);
      end
      checks++;
      if (bus_n.read_data1 !== 32'd11 || bus_n.read_data2 !== 32'd11) begin
         errors++;
         $display("FAIL nobypass_old: got %0d/%0d want 11", bus_n.read_data1, bus_n.read_data2);
      end
      tick();
      reg_write = 1'b0; write_data = 32'd77;
      #1;
      checks++;
      if (bus_b.read_data1 !== 32'd55 || bus_n.read_data1 !== 32'd55) begin
         errors++;
         $display("FAIL bypass_commit: got %0d/%0d want 55", bus_b.read_data1, bus_n.read_data1);
      end
   endtask

   task automatic test_reset_priority();
      logic [3:0][XLEN-1:0] obs;
      reg_write = 1'b1; write_reg = 5'd3; write_data = 32'd42;
      tick();
      rst = 1'b1; write_data = 32'd77; read_reg1 = 5'd3; read_reg2 = 5'd3;
      #1;
      obs = observed();
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (obs[k] !== '0) begin
            errors++;
            $display("FAIL rstprio_during port%0d: got %h want 0", k, obs[k]);
         end
      end
      tick();
      rst = 1'b0; reg_write = 1'b0;
      #1;
      obs = observed();
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (obs[k] !== '0) begin
            errors++;
            $display("FAIL rstprio_after port%0d: got %h want 0", k, obs[k]);
         end
      end
   endtask

   task automatic test_sweep();
      logic [3:0][XLEN-1:0] obs;
      logic [XLEN-1:0]      w1;
      logic [XLEN-1:0]      w2;
      reg_write = 1'b1;
      for (int i = 1; i < NREGS; i++) begin
         write_reg = AW'(i); write_data = XLEN'(i * 16 + 1);
         tick();
      end
      reg_write = 1'b0;
      for (int pass = 0; pass < 2; pass++) begin
         for (int i = 0; i < NREGS; i++) begin
            read_reg1 = AW'(i); read_reg2 = AW'(NREGS - 1 - i);
            w1 = (i == 0) ? '0 : XLEN'(i * 16 + 1);
            w2 = (i == NREGS - 1) ? '0 : XLEN'((NREGS - 1 - i) * 16 + 1);
            if (pass == 1 && i == NREGS - 1) w1 = 32'hFFFFFFFF;
            if (pass == 1 && i == 0) w2 = 32'hFFFFFFFF;
            #1;
            obs = observed();
            for (int k = 0; k < 4; k++) begin
               checks++;
               if (obs[k] !== ((k % 2 == 0) ? w1 : w2)) begin
                  errors++;
                  $display("FAIL sweep pass%0d i=%0d port%0d: got %h want %h", pass, i, k,
                           obs[k], (k % 2 == 0) ? w1 : w2);
               end
            end
         end
         reg_write = 1'b1; write_reg = 5'd31; write_data = 32'hFFFFFFFF;
         tick();
         reg_write = 1'b0;
      end
   endtask

   task automatic test_random();
      logic [3:0][XLEN-1:0] obs;
      logic [3:0][XLEN-1:0] exp;
      for (int n = 0; n < 400; n++) begin
         rst        = ($urandom_range(15) == 0);
         reg_write  = $urandom_range(1);
         write_reg  = AW'($urandom);
         write_data = $urandom;
         read_reg1  = ($urandom_range(2) == 0) ? write_reg : AW'($urandom);
         read_reg2  = ($urandom_range(2) == 0) ? read_reg1 : AW'($urandom);
         if (!reg_write && $urandom_range(3) == 0) write_data = 'x;
         #1;
         obs = observed();
         exp = expected();
         for (int k = 0; k < 4; k++) begin
            checks++;
            if (obs[k] !== exp[k]) begin
               errors++;
               $display("FAIL random n=%0d port%0d: got %h want %h", n, k, obs[k], exp[k]);
            end
         end
         tick();
      end
   endtask

   initial begin
      rst = 1'b1; reg_write = 1'b0; write_reg = '0; write_data = '0;
      read_reg1 = '0; read_reg2 = '0;
      for (int i = 0; i < NREGS; i++) model[i] = '0;
      test_reset();
      test_basic_write();
      test_x0();
      test_bypass();
      test_reset_priority();
      test_sweep();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- Integer register file for the 5-stage RISC-V pipeline: 32 general-purpose registers x0..x31, each 32 bits wide.
- Two asynchronous (combinational) read ports and one synchronous write port.
- Read ports are used in the decode stage; the write port is driven from write-back.
- x0 is hardwired to zero. Write-to-read bypass lets a decode-stage read see the value being written back in the same cycle.

Parameters:
- XLEN, 32, data width of each register and of the data ports.
- NREGS, 32, number of architectural registers; must be a power of two.
- AW, 5, register index width; must equal log2(NREGS).
- BYPASS, 1, 1 enables same-cycle write-to-read forwarding; 0 disables it (reads see array contents only).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- read_reg1  input  AW  index for read port 1.
- read_reg2  input  AW  index for read port 2.
- write_reg  input  AW  index for the write port.
- write_data  input  XLEN  data to write.
- reg_write  input  1  write enable.
- read_data1  output  XLEN  combinational read data, port 1.
- read_data2  output  XLEN  combinational read data, port 2.

Interface decision: one clock (clk); reset rst is synchronous and active-high.

Behaviour:
- Storage: NREGS x XLEN flops; no memory macro needed.
- Reset:
  - On a rising clk edge with rst=1, every register clears to 0.
  - rst has priority over reg_write; a write presented in that cycle is dropped.
  - While rst=1, read_data1 and read_data2 are forced to 0 combinationally, regardless of index or bypass.
- Write:
  - On a rising clk edge with rst=0, reg_write=1 and write_reg!=0: regs[write_reg] <= write_data.
  - The new value is visible in array reads from the next cycle.
  - reg_write=0 leaves all state unchanged.
  - A write to x0 is silently discarded.
- Read (per port n, evaluated combinationally):
  - If rst=1, output 0.
  - Else if read_reg_n==0, output 0.
  - Else if BYPASS=1, reg_write=1 and write_reg==read_reg_n, output write_data.
  - Else output regs[read_reg_n].
- Both ports may address the same register; both then return identical data, bypass included.
- Latency: read is 0 cycles (combinational). Write is 1 cycle (committed at the edge).
- No handshake and no illegal indices: every AW-bit index maps to a register.
- X-safety: outputs must never be X after the first reset edge, even if inputs hold X on a port that is not enabled.
- Reset asserted mid-operation, after writes: the next edge clears all registers, and reads return 0 from assertion onward.

Test Plan:
- Reset clears: hold rst=1 for 1 edge, release; read x1..x31 on both ports -> all 0.
- Basic write/read:
  - reg_write=1, write x5=123 on edge 1, then x10=999 on edge 2.
  - Then reg_write=0, read_reg1=5, read_reg2=10 -> read_data1=123, read_data2=999.
  - Values persist over further idle cycles.
- x0 hardwired: write x0=32'hDEADBEEF, then read x0 on both ports -> 0.
- Bypass and write-enable:
  - BYPASS=1: with reg_write=1, write_reg=7, write_data=55 and read_reg1=7, read_data1=55 before the edge.
  - Same stimulus with reg_write=0 -> old x7 value.
  - BYPASS=0 variant -> old value until after the edge.
- Reset priority:
  - Load x3=42; assert rst together with reg_write=1, write_reg=3, write_data=77.
  - After the edge and rst release -> x3 reads 0; while rst=1 both outputs read 0.
- Sweep: write r_i = i*16+1 to all 31 nonzero registers.
  - Read all pairs (i, 31-i) -> exact values, x0 reads 0.
  - Overwrite x31 with 32'hFFFFFFFF and confirm no other register changes.
